// File: rtl/simplebus_pkg.sv
// Shared encodings and entry layout for the SimpleBus response model.
// Address is stored zero-extended to a fixed maximum width.
package simplebus_pkg;

    localparam logic [3:0] CMD_READ      = 4'b0000;
    localparam logic [3:0] CMD_WRITE     = 4'b0001;
    localparam logic [3:0] CMD_WRITERESP = 4'b0101;
    localparam logic [3:0] CMD_READLAST  = 4'b0110;

    localparam logic [2:0] SIZE_MAX = 3'd3;
    localparam int ADDR_MAX_W = 64;

    typedef struct packed {
        logic                  is_write;
        logic [ADDR_MAX_W-1:0] addr;
    } entry_t;

    function automatic logic misaligned(
        input logic [2:0] lo,
        input logic [2:0] size
    );
        logic bad;
        bad = 1'b0;
        case (size)
            3'd1:    bad = lo[0];
            3'd2:    bad = |lo[1:0];
            3'd3:    bad = |lo;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/simplebus_resp_queue.sv
// One SimpleBus channel: request FIFO with per-entry ageing,
// response data latch and a sticky protocol checker.
module simplebus_resp_queue
    import simplebus_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 64,
    parameter int DEPTH   = 4,
    parameter int LATENCY = 2,
    localparam int CW     = $clog2(DEPTH + 1),
    localparam int PW     = $clog2(DEPTH),
    localparam int MW     = DW / 16,
    localparam int WW     = DW / 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          stall,
    input  logic [DW-1:0] rdata_in,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    input  logic [2:0]    req_size,
    input  logic [3:0]    req_cmd,
    input  logic [MW-1:0] req_wmask,
    input  logic [WW-1:0] req_wdata,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [3:0]    resp_cmd,
    output logic [DW-1:0] resp_rdata,
    output logic [CW-1:0] outstanding,
    output logic          proto_err
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [3:0]    LAT      = 4'(LATENCY);

    entry_t        mem [DEPTH];
    logic [3:0]    age [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count;
    logic          held;
    logic [DW-1:0] rdata_q;

    logic          push;
    logic          pop;
    logic          full;
    entry_t        head;
    entry_t        new_entry;
    logic [DW-1:0] live;

    assign full      = (count == FULL_CNT);
    assign req_ready = reset && !full && !stall;
    assign push      = req_valid && req_ready;
    assign pop       = resp_valid && resp_ready;
    assign head      = mem[rptr];
    assign new_entry = '{is_write: (req_cmd == CMD_WRITE),
                         addr:     ADDR_MAX_W'(req_addr)};

    assign outstanding = count;
    assign resp_valid  = (count != '0) && (age[rptr] == LAT);
    assign live        = head.is_write ? '0 : rdata_in;

    // First eligible cycle shows live data; later cycles show the latch.
    always_comb begin
        resp_rdata = '0;
        resp_cmd   = 4'b0000;
        if (resp_valid) begin
            resp_rdata = held ? rdata_q : live;
            resp_cmd   = head.is_write ? CMD_WRITERESP : CMD_READLAST;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            held    <= 1'b0;
            rdata_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
                age[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (age[i] != LAT) age[i] <= age[i] + 4'd1;
            end
            if (push) begin
                mem[wptr] <= new_entry;
                age[wptr] <= '0;
                wptr      <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (pop) begin
                held <= 1'b0;
            end else if (resp_valid && !held) begin
                held    <= 1'b1;
                rdata_q <= live;
            end
        end
    end

    logic          pend;
    logic [AW-1:0] prev_addr;
    logic [3:0]    prev_cmd;
    logic [2:0]    prev_size;
    logic          req_bad;
    logic          unstable;

    always_comb begin
        req_bad = 1'b0;
        if (req_cmd != CMD_READ && req_cmd != CMD_WRITE) req_bad = 1'b1;
        if (req_size > SIZE_MAX) req_bad = 1'b1;
        if (misaligned(req_addr[2:0], req_size)) req_bad = 1'b1;
        if (req_cmd == CMD_WRITE && req_wmask == '0) req_bad = 1'b1;
    end

    // A request left waiting must stay asserted with unchanged fields.
    assign unstable = pend && (!req_valid || req_addr != prev_addr ||
                               req_cmd != prev_cmd || req_size != prev_size);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend      <= 1'b0;
            prev_addr <= '0;
            prev_cmd  <= '0;
            prev_size <= '0;
            proto_err <= 1'b0;
        end else begin
            pend      <= req_valid && !req_ready;
            prev_addr <= req_addr;
            prev_cmd  <= req_cmd;
            prev_size <= req_size;
            if ((push && req_bad) || unstable) proto_err <= 1'b1;
        end
    end

endmodule

// File: rtl/simplebus_resp_model.sv
// Multi-channel SimpleBus slave model: one independent
// response queue per channel on flattened port buses.
module simplebus_resp_model
    import simplebus_pkg::*;
#(
    parameter int NCH     = 3,
    parameter int AW      = 32,
    parameter int DW      = 64,
    parameter int DEPTH   = 4,
    parameter int LATENCY = 2,
    localparam int OW     = $clog2(DEPTH + 1),
    localparam int MW     = DW / 16,
    localparam int WW     = DW / 2
) (
    input  logic [0:0]        clock,
    input  logic [0:0]        reset,
    input  logic [NCH-1:0]    stall,
    input  logic [NCH*DW-1:0] rdata_in,
    input  logic [NCH-1:0]    req_valid,
    output logic [NCH-1:0]    req_ready,
    input  logic [NCH*AW-1:0] req_addr,
    input  logic [NCH*3-1:0]  req_size,
    input  logic [NCH*4-1:0]  req_cmd,
    input  logic [NCH*MW-1:0] req_wmask,
    input  logic [NCH*WW-1:0] req_wdata,
    output logic [NCH-1:0]    resp_valid,
    input  logic [NCH-1:0]    resp_ready,
    output logic [NCH*4-1:0]  resp_cmd,
    output logic [NCH*DW-1:0] resp_rdata,
    output logic [NCH*OW-1:0] outstanding,
    output logic [NCH-1:0]    proto_err
);

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        simplebus_resp_queue #(
            .AW      (AW),
            .DW      (DW),
            .DEPTH   (DEPTH),
            .LATENCY (LATENCY)
        ) u_q (
            .clock       (clock),
            .reset       (reset),
            .stall       (stall[c]),
            .rdata_in    (rdata_in[c*DW +: DW]),
            .req_valid   (req_valid[c]),
            .req_ready   (req_ready[c]),
            .req_addr    (req_addr[c*AW +: AW]),
            .req_size    (req_size[c*3 +: 3]),
            .req_cmd     (req_cmd[c*4 +: 4]),
            .req_wmask   (req_wmask[c*MW +: MW]),
            .req_wdata   (req_wdata[c*WW +: WW]),
            .resp_valid  (resp_valid[c]),
            .resp_ready  (resp_ready[c]),
            .resp_cmd    (resp_cmd[c*4 +: 4]),
            .resp_rdata  (resp_rdata[c*DW +: DW]),
            .outstanding (outstanding[c*OW +: OW]),
            .proto_err   (proto_err[c])
        );
    end

endmodule

// File: tb/tb_simplebus_resp_model.sv
// Directed bench for simplebus_resp_model: latency, backpressure,
// data hold, write responses, protocol flags, stall and reset.
module tb_simplebus_resp_model;

    localparam int NCH = 3;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int DEPTH = 4;
    localparam int LATENCY = 2;
    localparam int OW = $clog2(DEPTH + 1);
    localparam int MW = DW / 16;
    localparam int WW = DW / 2;

    logic              clock = 1'b0;
    logic              reset;
    logic [NCH-1:0]    stall;
    logic [NCH*DW-1:0] rdata_in;
    logic [NCH-1:0]    req_valid;
    logic [NCH-1:0]    req_ready;
    logic [NCH*AW-1:0] req_addr;
    logic [NCH*3-1:0]  req_size;
    logic [NCH*4-1:0]  req_cmd;
    logic [NCH*MW-1:0] req_wmask;
    logic [NCH*WW-1:0] req_wdata;
    logic [NCH-1:0]    resp_valid;
    logic [NCH-1:0]    resp_ready;
    logic [NCH*4-1:0]  resp_cmd;
    logic [NCH*DW-1:0] resp_rdata;
    logic [NCH*OW-1:0] outstanding;
    logic [NCH-1:0]    proto_err;

    int vectors = 0;
    int miscompares = 0;

    simplebus_resp_model #(
        .NCH(NCH), .AW(AW), .DW(DW), .DEPTH(DEPTH), .LATENCY(LATENCY)
    ) dut (
        .clock(clock), .reset(reset), .stall(stall), .rdata_in(rdata_in),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_size(req_size), .req_cmd(req_cmd), .req_wmask(req_wmask),
        .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_cmd(resp_cmd),
        .resp_rdata(resp_rdata), .outstanding(outstanding),
        .proto_err(proto_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int ch, input logic v, input logic [3:0] cmd,
                         input logic [2:0] size, input logic [AW-1:0] addr,
                         input logic [MW-1:0] mask);
        req_valid[ch]           = v;
        req_cmd[ch*4 +: 4]      = cmd;
        req_size[ch*3 +: 3]     = size;
        req_addr[ch*AW +: AW]   = addr;
        req_wmask[ch*MW +: MW]  = mask;
    endtask

    function automatic logic [63:0] rd(input int ch);
        return resp_rdata[ch*DW +: DW];
    endfunction

    function automatic logic [63:0] rc(input int ch);
        return 64'(resp_cmd[ch*4 +: 4]);
    endfunction

    function automatic logic [63:0] oc(input int ch);
        return 64'(outstanding[ch*OW +: OW]);
    endfunction

    initial begin
        reset = 1'b0;
        stall = '0;
        rdata_in = '0;
        req_valid = '0;
        req_addr = '0;
        req_size = '0;
        req_cmd = '0;
        req_wmask = '0;
        req_wdata = '0;
        resp_ready = '0;

        repeat (3) step();
        chk("rst_ready", 64'(req_ready), 64'h0);
        chk("rst_rvalid", 64'(resp_valid), 64'h0);
        chk("rst_outst", 64'(outstanding), 64'h0);
        chk("rst_perr", 64'(proto_err), 64'h0);
        chk("rst_rdata0", rd(0), 64'h0);
        reset = 1'b1;
        step();
        chk("post_rst_ready", 64'(req_ready), 64'h7);

        // latency: accept edge, two ageing cycles, then response
        resp_ready[0] = 1'b1;
        rdata_in[0 +: DW] = 64'hDEAD_BEEF_0000_1111;
        drive(0, 1'b1, 4'b0000, 3'd3, 32'h8000_0000, '0);
        #1 chk("t1_ready", 64'(req_ready[0]), 64'h1);
        step();
        req_valid[0] = 1'b0;
        #1 chk("t1_outst1", oc(0), 64'h1);
        chk("t1_nv_a", 64'(resp_valid[0]), 64'h0);
        step();
        #1 chk("t1_nv_b", 64'(resp_valid[0]), 64'h0);
        step();
        #1 chk("t1_valid", 64'(resp_valid[0]), 64'h1);
        chk("t1_cmd", rc(0), 64'h6);
        chk("t1_rdata", rd(0), 64'hDEAD_BEEF_0000_1111);
        step();
        #1 chk("t1_outst0", oc(0), 64'h0);
        chk("t1_gone", 64'(resp_valid[0]), 64'h0);

        // fill channel 1, fifth request held until space frees
        resp_ready[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1, 1'b1, 4'b0000, 3'd3, 32'h100 + 32'(8 * i), '0);
            #1 chk("t2_ready_fill", 64'(req_ready[1]), 64'h1);
            step();
        end
        drive(1, 1'b1, 4'b0000, 3'd3, 32'h120, '0);
        #1 chk("t2_full_ready", 64'(req_ready[1]), 64'h0);
        chk("t2_full_outst", oc(1), 64'h4);
        repeat (3) step();
        #1 chk("t2_hold_ready", 64'(req_ready[1]), 64'h0);
        chk("t2_hold_outst", oc(1), 64'h4);
        resp_ready[1] = 1'b1;
        #1 chk("t2_d1_valid", 64'(resp_valid[1]), 64'h1);
        chk("t2_d1_ready", 64'(req_ready[1]), 64'h0);
        step();
        #1 chk("t2_d2_ready", 64'(req_ready[1]), 64'h1);
        chk("t2_d2_valid", 64'(resp_valid[1]), 64'h1);
        step();
        req_valid[1] = 1'b0;
        #1 chk("t2_d3_outst", oc(1), 64'h3);
        for (int j = 0; j < 3; j++) begin
            chk("t2_drain_valid", 64'(resp_valid[1]), 64'h1);
            chk("t2_drain_cmd", rc(1), 64'h6);
            step();
        end
        chk("t2_empty_outst", oc(1), 64'h0);
        chk("t2_empty_valid", 64'(resp_valid[1]), 64'h0);
        chk("t2_no_perr", 64'(proto_err[1]), 64'h0);

        // data latched on first eligible cycle and held
        resp_ready[0] = 1'b0;
        drive(0, 1'b1, 4'b0000, 3'd3, 32'h200, '0);
        step();
        drive(0, 1'b1, 4'b0000, 3'd3, 32'h208, '0);
        step();
        req_valid[0] = 1'b0;
        #1 chk("t3_nv", 64'(resp_valid[0]), 64'h0);
        chk("t3_outst2", oc(0), 64'h2);
        step();
        rdata_in[0 +: DW] = 64'hAAAA_0000_0000_0001;
        #1 chk("t3_valid", 64'(resp_valid[0]), 64'h1);
        chk("t3_first", rd(0), 64'hAAAA_0000_0000_0001);
        step();
        rdata_in[0 +: DW] = 64'hBBBB_0000_0000_0002;
        #1 chk("t3_hold1", rd(0), 64'hAAAA_0000_0000_0001);
        step();
        rdata_in[0 +: DW] = 64'hCCCC_0000_0000_0003;
        #1 chk("t3_hold2", rd(0), 64'hAAAA_0000_0000_0001);
        resp_ready[0] = 1'b1;
        #1 chk("t3_hold3", rd(0), 64'hAAAA_0000_0000_0001);
        step();
        rdata_in[0 +: DW] = 64'hDDDD_0000_0000_0004;
        #1 chk("t3_next_valid", 64'(resp_valid[0]), 64'h1);
        chk("t3_next_data", rd(0), 64'hDDDD_0000_0000_0004);
        step();
        #1 chk("t3_outst0", oc(0), 64'h0);

        // write response
        resp_ready[2] = 1'b1;
        rdata_in[2*DW +: DW] = 64'h5555_AAAA_5555_AAAA;
        drive(2, 1'b1, 4'b0001, 3'd2, 32'h10, 4'hF);
        step();
        req_valid[2] = 1'b0;
        step();
        step();
        #1 chk("t4_valid", 64'(resp_valid[2]), 64'h1);
        chk("t4_cmd", rc(2), 64'h5);
        chk("t4_rdata", rd(2), 64'h0);
        chk("t4_perr_a", 64'(proto_err[2]), 64'h0);
        step();
        #1 chk("t4_perr_b", 64'(proto_err[2]), 64'h0);
        chk("t4_outst0", oc(2), 64'h0);

        // illegal cmd on ch0, misaligned on ch2
        rdata_in[0 +: DW] = 64'h0123_4567_89AB_CDEF;
        drive(0, 1'b1, 4'b0010, 3'd3, 32'h20, '0);
        drive(2, 1'b1, 4'b0000, 3'd2, 32'h2, '0);
        step();
        req_valid = '0;
        #1 chk("t5_perr", 64'(proto_err), 64'h5);
        step();
        step();
        #1 chk("t5_cmd0", rc(0), 64'h6);
        chk("t5_rdata0", rd(0), 64'h0123_4567_89AB_CDEF);
        chk("t5_cmd2", rc(2), 64'h6);
        step();
        #1 chk("t5_sticky", 64'(proto_err), 64'h5);
        chk("t5_outst", 64'(outstanding), 64'h0);

        // per-channel stall
        stall = 3'b010;
        #1 chk("t6_stall", 64'(req_ready), 64'h5);
        stall = '0;
        #1 chk("t6_unstall", 64'(req_ready), 64'h7);

        // reset with an entry pending
        resp_ready[0] = 1'b0;
        drive(0, 1'b1, 4'b0000, 3'd3, 32'h300, '0);
        step();
        req_valid[0] = 1'b0;
        step();
        step();
        #1 chk("t6_pre_valid", 64'(resp_valid[0]), 64'h1);
        chk("t6_pre_outst", oc(0), 64'h1);
        reset = 1'b0;
        #1 chk("t6_rst_outst", 64'(outstanding), 64'h0);
        chk("t6_rst_valid", 64'(resp_valid), 64'h0);
        chk("t6_rst_perr", 64'(proto_err), 64'h0);
        step();
        reset = 1'b1;
        repeat (3) step();
        chk("t6_after_valid", 64'(resp_valid), 64'h0);
        chk("t6_after_outst", 64'(outstanding), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
